// File: rtl/iir_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : iir_sample_sequencer
// Description : Block sequencer between the IIR register file and the filter
//               datapath. Buffers one block of input samples, clears the
//               filter, streams the samples out over valid/ready, captures
//               the filtered results and raises sticky done/error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_sample_sequencer #(
  parameter int DW      = 32,
  parameter int DEPTH   = 32,
  parameter int IW      = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // register-file side
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  // datapath side
  output logic          core_clear_o,
  output logic          x_valid_o,
  input  logic          x_ready_i,
  output logic [DW-1:0] x_data_o,
  input  logic          y_valid_i,
  input  logic [DW-1:0] y_data_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [IW:0]   c_CNT_FULL = (IW+1)'(DEPTH);
  localparam logic [IW:0]   c_CNT_LAST = (IW+1)'(DEPTH - 1);
  localparam logic [IW:0]   c_CNT_ONE  = (IW+1)'(1);
  localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] c_TMO_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          start_q;
  logic [IW:0]   in_cnt_q, in_cnt_d;
  logic [IW:0]   out_cnt_q, out_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] rd_data_q;

  logic [DW-1:0] inbuf_q  [DEPTH];
  logic [DW-1:0] outbuf_q [DEPTH];

  logic start_edge;
  logic active;
  logic x_hs;
  logic x_last;
  logic y_cap;
  logic out_full;

  assign start_edge = start_i & ~start_q;
  assign active     = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign x_hs       = (state_q == S_STREAM) && x_ready_i;
  assign x_last     = x_hs && (in_cnt_q == c_CNT_LAST);
  // results past the end of the block are dropped
  assign y_cap      = active && y_valid_i && (out_cnt_q != c_CNT_FULL);
  // result buffer is (or becomes this cycle) completely filled
  assign out_full   = (out_cnt_q == c_CNT_FULL) ||
                      (y_cap && (out_cnt_q == c_CNT_LAST));

  assign busy_o       = (state_q == S_CLEAR) || active;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign core_clear_o = (state_q == S_CLEAR);
  assign x_valid_o    = (state_q == S_STREAM);
  // the counter only advances on a handshake, so the sample holds while stalled
  assign x_data_o     = inbuf_q[in_cnt_q[IW-1:0]];
  assign rd_data_o    = rd_data_q;

  // Control state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_i;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: sequencing, counters, timeout and sticky flags
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    tmo_d     = tmo_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_d   = S_CLEAR;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          tmo_d     = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
      end
      S_STREAM, S_DRAIN: begin
        if (x_hs)  in_cnt_d  = in_cnt_q + c_CNT_ONE;
        if (y_cap) out_cnt_d = out_cnt_q + c_CNT_ONE;
        tmo_d = y_valid_i ? '0 : (tmo_q + c_TMO_ONE);
        if (x_last) state_d = S_DRAIN;
        // completion needs every sample sent and every result captured
        if (((state_q == S_DRAIN) || x_last) && out_full) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (!y_valid_i && (tmo_q == c_TMO_LAST)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Input buffer: writable by software only while no block is running
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_o) begin
      inbuf_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Result buffer: capture datapath output in arrival order
  always_ff @(posedge clk_i) begin
    if (!rst_i && y_cap) begin
      outbuf_q[out_cnt_q[IW-1:0]] <= y_data_i;
    end
  end

  // Registered result readback; same-cycle write shows old data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= outbuf_q[rd_idx_i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_sample_sequencer
// Description : Self-checking bench for iir_sample_sequencer with a 1-cycle
//               identity datapath model and a result scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_sample_sequencer;

  localparam int DW      = 32;
  localparam int DEPTH   = 32;
  localparam int IW      = 5;
  localparam int TIMEOUT = 1024;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wr_en_i;
  logic [IW-1:0] wr_idx_i;
  logic [DW-1:0] wr_data_i;
  logic [IW-1:0] rd_idx_i;
  logic [DW-1:0] rd_data_o;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic          core_clear_o;
  logic          x_valid_o;
  logic          x_ready_i;
  logic [DW-1:0] x_data_o;
  logic          y_valid_i;
  logic [DW-1:0] y_data_i;

  iir_sample_sequencer #(
    .DW(DW), .DEPTH(DEPTH), .IW(IW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
    .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .core_clear_o(core_clear_o),
    .x_valid_o(x_valid_o), .x_ready_i(x_ready_i), .x_data_o(x_data_o),
    .y_valid_i(y_valid_i), .y_data_i(y_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;

  // bench-side models
  logic [DW-1:0] mirror [DEPTH];   // what software wrote into the input buffer
  logic [DW-1:0] shadow [DEPTH];   // expected result buffer contents
  logic [DW-1:0] sb_q [$];         // expected results, in capture order
  int  cyc       = 0;
  int  hs_n      = 0;
  int  y_n       = 0;
  int  y_lim     = 1000;
  int  y_last    = -1;
  int  done_cyc  = -1;
  int  clr_total = 0;
  int  ph        = 0;
  bit  bp_mode   = 1'b0;
  bit  hs_pend   = 1'b0;
  logic [DW-1:0] hs_dat;
  logic [DW-1:0] hs_exp;

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive datapath/ready just after the edge, observe at negedge
  task automatic tick();
    @(posedge clk_i);
    cyc++;
    #1;
    if (rst_i) begin
      hs_pend = 1'b0;
      sb_q.delete();
    end
    y_valid_i = hs_pend && (y_n < y_lim);
    y_data_i  = hs_dat;
    if (y_valid_i) begin
      sb_q.push_back(hs_exp);
      y_n++;
      y_last = cyc;
    end
    hs_pend   = 1'b0;
    x_ready_i = bp_mode ? (ph == 0) : 1'b1;
    ph        = (ph == 2) ? 0 : ph + 1;
    @(negedge clk_i);
    if (core_clear_o) begin
      clr_total++;
      hs_n = 0;
      y_n  = 0;
    end
    if (done_o && done_cyc < 0) done_cyc = cyc;
    if (!rst_i && x_valid_o && hs_n < DEPTH) begin
      check_val("x_data", x_data_o, mirror[hs_n]);
      if (x_ready_i) begin
        hs_pend = 1'b1;
        hs_dat  = x_data_o;
        hs_exp  = mirror[hs_n];
        hs_n++;
      end
    end
  endtask

  task automatic write_in(input int idx, input logic [DW-1:0] val);
    wr_en_i   = 1'b1;
    wr_idx_i  = IW'(idx);
    wr_data_i = val;
    mirror[idx] = val;
    tick();
    wr_en_i = 1'b0;
  endtask

  // inject: 1 = attempt a write and a second start while streaming
  task automatic run_block(input bit bp, input int ylim, input bit inject,
                           input bit exp_err);
    int  ks;
    int  clr0;
    bit  injected;
    logic [DW-1:0] exp;
    injected = 1'b0;
    done_cyc = -1;
    clr0     = clr_total;
    bp_mode  = bp;
    y_lim    = ylim;
    ph       = 0;
    start_i  = 1'b1;
    ks       = cyc;
    tick();
    check_val("clear_at_k1", {31'd0, core_clear_o}, 32'd1);
    check_val("busy_at_k1", {31'd0, busy_o}, 32'd1);
    check_val("done_cleared", {31'd0, done_o}, 32'd0);
    start_i = 1'b0;
    for (int n = 0; n < 3000 && !done_o; n++) begin
      if (inject && !injected && hs_n == 3) begin
        wr_en_i   = 1'b1;
        wr_idx_i  = IW'(5);
        wr_data_i = 32'hdead_beef;
        start_i   = 1'b1;
        injected  = 1'b1;
      end else begin
        wr_en_i = 1'b0;
        start_i = 1'b0;
      end
      tick();
      if (!done_o && !err_o) check_val("busy_run", {31'd0, busy_o}, 32'd1);
    end
    wr_en_i = 1'b0;
    start_i = 1'b0;
    check_val("done", {31'd0, done_o}, 32'd1);
    check_val("err", {31'd0, err_o}, {31'd0, exp_err});
    check_val("busy_end", {31'd0, busy_o}, 32'd0);
    check_val("x_valid_end", {31'd0, x_valid_o}, 32'd0);
    check_val("sent_count", 32'(hs_n), 32'(DEPTH));
    check_val("clear_pulses", 32'(clr_total - clr0), 32'd1);
    if (exp_err) begin
      // abort lands about TIMEOUT idle cycles after the last result
      check_val("tmo_delay_ok",
                {31'd0, (done_cyc - y_last >= TIMEOUT) &&
                        (done_cyc - y_last <= TIMEOUT + 1)}, 32'd1);
    end else begin
      check_val("result_count", 32'(y_n), 32'(DEPTH));
      check_val("done_after_last", 32'(done_cyc - y_last), 32'd1);
      if (!bp) check_val("done_latency", 32'(done_cyc - ks), 32'd35);
    end
    // read back: popped scoreboard entries first, older contents after
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx_i = IW'(i);
      tick();
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        shadow[i] = exp;
      end else begin
        exp = shadow[i];
      end
      check_val($sformatf("rd[%0d]", i), rd_data_o, exp);
    end
  endtask

  initial begin
    rst_i     = 1'b1;
    wr_en_i   = 1'b0;
    wr_idx_i  = '0;
    wr_data_i = '0;
    rd_idx_i  = '0;
    start_i   = 1'b0;
    x_ready_i = 1'b1;
    y_valid_i = 1'b0;
    y_data_i  = '0;
    hs_dat    = '0;
    hs_exp    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mirror[i] = '0;
      shadow[i] = '0;
    end
    tick();
    tick();
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_done", {31'd0, done_o}, 32'd0);
    check_val("rst_err", {31'd0, err_o}, 32'd0);
    check_val("rst_xvalid", {31'd0, x_valid_o}, 32'd0);
    check_val("rst_clear", {31'd0, core_clear_o}, 32'd0);
    check_val("rst_rdata", rd_data_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // nominal block
    for (int i = 0; i < DEPTH; i++) write_in(i, 32'(4 * i));
    run_block(1'b0, 1000, 1'b0, 1'b0);

    // backpressure 1,0,0
    run_block(1'b1, 1000, 1'b0, 1'b0);
    bp_mode = 1'b0;

    // write and start while streaming must be ignored
    run_block(1'b0, 1000, 1'b1, 1'b0);

    // timeout after 10 results; new input data distinguishes fresh entries
    for (int i = 0; i < DEPTH; i++) write_in(i, 32'(4 * i + 7));
    run_block(1'b0, 10, 1'b0, 1'b1);

    // reset in the middle of a stream
    for (int i = 0; i < DEPTH; i++) write_in(i, 32'(4 * i));
    y_lim   = 1000;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int n = 0; n < 200 && hs_n < 12; n++) tick();
    check_val("mid_in_stream", {31'd0, x_valid_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    check_val("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("mid_rst_xvalid", {31'd0, x_valid_o}, 32'd0);
    check_val("mid_rst_done", {31'd0, done_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    run_block(1'b0, 1000, 1'b0, 1'b0);

    // restart from DONE with negated samples
    check_val("pre_restart_done", {31'd0, done_o}, 32'd1);
    for (int i = 0; i < DEPTH; i++) write_in(i, 32'(-i));
    run_block(1'b0, 1000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
